// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its bit serializer.
package uart_pkg;

   localparam int   DEFAULT_DELAY_FRAMES = 234;
   localparam logic UART_IDLE_LVL        = 1'b1;

   typedef enum logic {
      ST_IDLE,
      ST_OWN
   } arb_state_e;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_START,
      SER_DATA,
      SER_STOP
   } ser_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 LSB-first serializer; tx drops the cycle after start, each bit lasts DELAY_FRAMES cycles.
// idle returns the cycle after the stop bit; start is ignored while a byte is on the wire.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       idle
);

   localparam int             BW        = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(DELAY_FRAMES - 1);

   ser_state_e    state_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SER_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= UART_IDLE_LVL;
      end else begin
         case (state_q)
            SER_IDLE: begin
               if (start) begin
                  state_q <= SER_START;
                  baud_q  <= '0;
                  shift_q <= data;
                  tx_q    <= ~UART_IDLE_LVL;
               end
            end
            SER_START: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= SER_DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            SER_DATA: begin
               // shift_q[0] is on the wire, so shift_q[1] is the next bit out
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= UART_IDLE_LVL;
                     state_q <= SER_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            SER_STOP: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q  <= '0;
                  state_q <= SER_IDLE;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= SER_IDLE;
         endcase
      end
   end

   assign tx   = tx_q;
   assign idle = (state_q == SER_IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin share of one UART line; req_ready is a same-cycle accept pulse
// given only to the owner when the serializer is idle, and a stalled owner is aborted after GAP_TIMEOUT.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int  DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
   parameter int  NUM_REQ      = 3,
   parameter int  GAP_TIMEOUT  = 4096,
   localparam int IDW          = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 uart_tx,
   output logic                 busy,
   output logic [IDW-1:0]       grant_id,
   output logic                 abort
);

   localparam int GW = $clog2(GAP_TIMEOUT + 1);

   arb_state_e     state_q;
   logic [IDW-1:0] rr_q, grant_q;
   logic           last_q, busy_q, abort_q;
   logic [GW-1:0]  gap_q;

   logic [IDW-1:0] pick_d, rr_next;
   logic [GW-1:0]  gap_d;
   logic [7:0]     req_byte [NUM_REQ];
   logic           ser_idle, own_valid, accept, gap_tick, gap_fire;
   logic [7:0]     ser_data;

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         req_byte[k] = req_data[k*8 +: 8];
      end
      ser_data  = req_byte[grant_q];
      own_valid = req_valid[grant_q];
      accept    = (state_q == ST_OWN) && ser_idle && !last_q && own_valid;
      gap_tick  = (state_q == ST_OWN) && ser_idle && !last_q && !own_valid;
      gap_d     = gap_q + 1'b1;
      gap_fire  = gap_tick && (gap_d == GW'(GAP_TIMEOUT));
      rr_next   = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      req_ready = '0;
      if (accept) begin
         req_ready[grant_q] = 1'b1;
      end
   end

   // Walk down from the farthest candidate so the nearest one to rr_q wins.
   always_comb begin
      int             sum;
      logic [IDW-1:0] cand;
      sum    = 0;
      cand   = '0;
      pick_d = rr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum = int'(rr_q) + k;
         if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
         end
         cand = IDW'(sum);
         if (req_valid[cand]) begin
            pick_d = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         abort_q <= 1'b0;
         gap_q   <= '0;
      end else begin
         abort_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|req_valid) begin
                  grant_q <= pick_d;
                  state_q <= ST_OWN;
                  busy_q  <= 1'b1;
                  last_q  <= 1'b0;
                  gap_q   <= '0;
               end
            end
            ST_OWN: begin
               if (accept) begin
                  gap_q  <= '0;
                  last_q <= req_last[grant_q];
               end else if (last_q && ser_idle) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  rr_q    <= rr_next;
               end else if (gap_fire) begin
                  abort_q <= 1'b1;
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  rr_q    <= rr_next;
                  gap_q   <= '0;
               end else if (gap_tick) begin
                  gap_q <= gap_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   uart_tx_serializer #(
      .DELAY_FRAMES(DELAY_FRAMES)
   ) u_ser (
      .clk  (clk),
      .rst_n(rst_n),
      .start(accept),
      .data (ser_data),
      .tx   (uart_tx),
      .idle (ser_idle)
   );

   assign busy     = busy_q;
   assign grant_id = grant_q;
   assign abort    = abort_q;

endmodule
